// File: rtl/fp_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_pkg : shared types and constants for the FP add normalize/pack stage    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          EXP_W   = 8;
    localparam int          FRAC_W  = 23;
    localparam int          SIG_W   = 25;
    localparam int          BIAS    = 127;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/fp_special_detect.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_special_detect : classifies two IEEE-754 singles and resolves NaN/inf   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fp_special_detect
    import fp_pkg::*;
(
    input  logic [31:0] x_i,
    input  logic [31:0] y_i,
    output logic        hit_o,
    output logic [31:0] result_o,
    output logic        both_zero_o
);

    logic x_nan, y_nan, x_inf, y_inf;

    always_comb begin
        x_nan       = (x_i[30:23] == EXP_MAX) && (x_i[22:0] != '0);
        y_nan       = (y_i[30:23] == EXP_MAX) && (y_i[22:0] != '0);
        x_inf       = (x_i[30:23] == EXP_MAX) && (x_i[22:0] == '0);
        y_inf       = (y_i[30:23] == EXP_MAX) && (y_i[22:0] == '0);
        both_zero_o = (x_i[30:0] == '0) && (y_i[30:0] == '0);
        hit_o       = 1'b0;
        result_o    = '0;
        if (x_nan || y_nan) begin
            hit_o    = 1'b1;
            result_o = QNAN;
        end else if (x_inf && y_inf && (x_i[31] != y_i[31])) begin
            hit_o    = 1'b1;
            result_o = QNAN;
        end else if (x_inf) begin
            hit_o    = 1'b1;
            result_o = x_i;
        end else if (y_inf) begin
            hit_o    = 1'b1;
            result_o = y_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_normalize_pack.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_normalize_pack : special-case resolve, 1-bit/cycle normalize, pack      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fp_normalize_pack
    import fp_pkg::*;
#(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     d_X,
    input  logic [N-1:0]     d_Y,
    input  logic [SIG_W-1:0] d_sig,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     q_R
);

    state_t             state_q, state_d;
    logic [N-1:0]       x_q, x_d, y_q, y_d, r_q, r_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [EXP_W:0]     exp_q, exp_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               sign_q, sign_d;

    logic               spec_hit, both_zero;
    logic [N-1:0]       spec_res;
    logic [EXP_W:0]     exp_inc;

    fp_special_detect u_special (
        .x_i         (x_q),
        .y_i         (y_q),
        .hit_o       (spec_hit),
        .result_o    (spec_res),
        .both_zero_o (both_zero)
    );

    assign exp_inc = exp_q + 9'd1;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sig_d   = sig_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        r_d     = r_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = d_X;
                    y_d     = d_Y;
                    sig_d   = d_sig;
                    exp_d   = (d_X[30:23] >= d_Y[30:23]) ? {1'b0, d_X[30:23]}
                                                         : {1'b0, d_Y[30:23]};
                    sign_d  = (d_X[30:0] >= d_Y[30:0]) ? d_X[31] : d_Y[31];
                    cnt_d   = '0;
                    state_d = NORM;
                end
            end
            NORM: begin
                state_d = DONE;
                if (spec_hit) begin
                    r_d = spec_res;
                end else if ((sig_q == '0) || both_zero) begin
                    r_d = '0;
                end else if (sig_q[24]) begin
                    // Carry-out: one right shift, possibly overflowing to inf
                    if (exp_inc >= 9'd255)
                        r_d = {sign_q, EXP_MAX, 23'b0};
                    else
                        r_d = {sign_q, exp_inc[7:0], sig_q[23:1]};
                end else if (sig_q[23]) begin
                    r_d = {sign_q, exp_q[7:0], sig_q[22:0]};
                end else if ((exp_q <= 9'd1) || (cnt_q >= 5'd23)) begin
                    r_d = {sign_q, 8'h00, sig_q[22:0]};
                end else begin
                    sig_d   = sig_q << 1;
                    exp_d   = exp_q - 9'd1;
                    cnt_d   = cnt_q + 5'd1;
                    state_d = NORM;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            sig_q   <= '0;
            exp_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            r_q     <= '0;
        end else if (en) begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sig_q   <= sig_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            r_q     <= r_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign q_R       = r_q;

endmodule
`default_nettype wire
